mc_main_control: RTL
====================

// Module: mc_main_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. It produces i_aluOp for the ALU control decoder,
//  plus every mux select and write strobe for PC, IR, register file and memory. It sequences
//  instructions through FETCH/DECODE/EXECUTE/MEM/WB and waits on a memory ready handshake.
//  Supported opcodes: R-type, lw, sw, beq, addi, j. Any other opcode is flagged and skipped.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles spent waiting for i_memReady in a mem state; 0 = wait forever
// PORTS
//  i_clk        in   1   clock; all state changes on rising edge
//  i_rst        in   1   synchronous, active-high reset
//  i_opcode     in   6   IR[31:26], stable from the cycle after IR write
//  i_memReady   in   1   memory has completed the current read/write this cycle
//  o_aluOp      out  2   00 add, 01 sub, 10 use func field (to ALU control decoder)
//  o_aluSrcA    out  1   0 PC, 1 reg A
//  o_aluSrcB    out  2   00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  o_pcSrc      out  2   00 ALU result, 01 ALUOut reg, 10 jump target
//  o_pcWrite    out  1   unconditional PC write
//  o_branch     out  1   PC write qualified by ALU zero (datapath ANDs)
//  o_iorD       out  1   memory address: 0 PC, 1 ALUOut
//  o_memRead    out  1   memory read request
//  o_memWrite   out  1   memory write request
//  o_irWrite    out  1   load IR from memory data
//  o_regWrite   out  1   register file write
//  o_regDst     out  1   dest reg: 0 rt, 1 rd
//  o_memToReg   out  1   write data: 0 ALUOut, 1 MDR
//  o_illegal    out  1   1-cycle pulse: unsupported opcode seen in DECODE
//  o_memErr     out  1   1-cycle pulse: memory timeout, instruction aborted
//  o_state      out  4   current state encoding (debug)
// BEHAVIOUR
//  - Reset: state=FETCH, timeout counter=0, o_illegal=o_memErr=0. While i_rst=1, all strobes
//    (pcWrite, branch, memRead, memWrite, irWrite, regWrite) are forced to 0 and selects are 0.
//    Reset mid-instruction aborts it with no writes.
//  - Moore outputs are decoded from registered state. Unlisted outputs are 0.
//  - FETCH(0): memRead, iorD=0, srcA=0, srcB=01, aluOp=00, pcSrc=00. irWrite and pcWrite are
//    asserted only when i_memReady=1. On ready, go to DECODE; otherwise stay.
//  - DECODE(1): srcA=0, srcB=11, aluOp=00 (branch target into ALUOut). Dispatch on i_opcode:
//    lw/sw go to MEMADR(2); R go to EXEC(6); beq goes to BRANCH(8); addi goes to ADDIEX(9);
//    j goes to JUMP(11). Any other opcode pulses o_illegal and goes to FETCH.
//  - MEMADR(2): srcA=1, srcB=10, aluOp=00. Go to MEMRD(3) for lw, MEMWR(5) for sw.
//  - MEMRD(3): memRead, iorD=1. Go to MEMWB(4) on ready.
//  - MEMWB(4): regWrite, regDst=0, memToReg=1. Then FETCH.
//  - MEMWR(5): memWrite, iorD=1. Go to FETCH on ready.
//  - EXEC(6): srcA=1, srcB=00, aluOp=10. Then ALUWB(7).
//  - ALUWB(7): regWrite, regDst=1. Then FETCH.
//  - BRANCH(8): srcA=1, srcB=00, aluOp=01, branch=1, pcSrc=01. Then FETCH.
//  - ADDIEX(9): srcA=1, srcB=10, aluOp=00. Then ADDIWB(10).
//  - ADDIWB(10): regWrite, regDst=0. Then FETCH.
//  - JUMP(11): pcWrite, pcSrc=10. Then FETCH.
//  - Encodings 12-15 are unreachable; if entered, next state is FETCH.
//  - Timeout: the counter clears on entering or leaving FETCH/MEMRD/MEMWR and increments each
//    cycle spent waiting there. If MEM_TIMEOUT!=0 and count==MEM_TIMEOUT-1 with no ready:
//    pulse o_memErr, go to FETCH, and suppress all strobes that cycle.
//    Ready on the same cycle as the limit counts as success.
//  - Latency: R/addi take 4 cycles, lw 5, sw 4, beq/j 3, each plus memory wait cycles.
// STRUCTURE
//  - mips_ctrl_pkg: state localparams, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//    OP_ADDI, OP_J), aluOp encodings (ALUOP_ADD/SUB/FUNC), aluSrcB/pcSrc encodings.
//  - Sub-module mc_ctrl_decode: combinational state -> control word (Moore decode).
//    Next-state logic, timeout counter and pulses stay in the top.
// TESTING
//  - Reset held 3 cycles then released, ready=1 -> state 0 in the first cycle, then 1. No strobe while i_rst=1.
//  - R-type (op 000000), ready=1 -> states 0,1,6,7,0. aluOp=10 in state 6, regWrite+regDst=1 in state 7.
//  - lw (100011) with ready delayed 2 cycles in MEMRD -> states 0,1,2,3,3,3,4. memToReg=1 and regWrite in state 4.
//  - beq (000100) -> state 8 with aluOp=01, branch=1, pcSrc=01. j (000010) -> state 11 with pcWrite=1, pcSrc=10.
//  - Opcode 111111 in DECODE -> o_illegal high exactly 1 cycle, next state 0, no regWrite/memWrite.
//  - MEM_TIMEOUT=4, sw with ready never asserted -> o_memErr pulses on the 4th MEMWR cycle, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and control-field encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: Moore decode of the registered control state into the raw control word
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // per-state control word; FETCH write strobes are qualified by memory ready in the top
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS main control FSM with memory-ready handshake and timeout
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_memReady,
    output logic [1:0] o_aluOp,
    output logic       o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_pcSrc,
    output logic       o_pcWrite,
    output logic       o_branch,
    output logic       o_iorD,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic       o_regDst,
    output logic       o_memToReg,
    output logic       o_illegal,
    output logic       o_memErr,
    output logic [3:0] o_state
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        state, state_nx;
    ctrl_t         cw;
    logic [CW-1:0] cnt;
    logic          wait_st, timeout, illegal, kill;

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (cw)
    );

    assign wait_st = state inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign timeout = (MEM_TIMEOUT != 0) && wait_st && !i_memReady && (cnt == CW'(MEM_TIMEOUT - 1));
    assign kill    = i_rst || timeout;

    // next-state dispatch; a memory timeout overrides everything and abandons the instruction
    always_comb begin
        state_nx = S_FETCH;
        illegal  = 1'b0;
        case (state)
            S_FETCH:  state_nx = i_memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXEC;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
                    default:      illegal  = 1'b1;
                endcase
            end
            S_MEMADR: state_nx = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nx = i_memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nx = i_memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nx = S_ALUWB;
            S_ADDIEX: state_nx = S_ADDIWB;
            default:  state_nx = S_FETCH;
        endcase
        if (timeout) state_nx = S_FETCH;
    end

    // state register and wait counter; the counter only runs while parked in a memory wait state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (wait_st && state_nx == state && !timeout) ? cnt + CW'(1) : '0;
        end
    end

    assign o_state    = state;
    assign o_aluOp    = i_rst ? 2'b00 : cw.alu_op;
    assign o_aluSrcA  = !i_rst && cw.alu_src_a;
    assign o_aluSrcB  = i_rst ? 2'b00 : cw.alu_src_b;
    assign o_pcSrc    = i_rst ? 2'b00 : cw.pc_src;
    assign o_iorD     = !i_rst && cw.ior_d;
    assign o_regDst   = !i_rst && cw.reg_dst;
    assign o_memToReg = !i_rst && cw.mem_to_reg;
    assign o_pcWrite  = !kill && cw.pc_write && (state != S_FETCH || i_memReady);
    assign o_irWrite  = !kill && cw.ir_write && i_memReady;
    assign o_branch   = !kill && cw.branch;
    assign o_memRead  = !kill && cw.mem_read;
    assign o_memWrite = !kill && cw.mem_write;
    assign o_regWrite = !kill && cw.reg_write;
    assign o_illegal  = !i_rst && illegal;
    assign o_memErr   = !i_rst && timeout;

endmodule
